prg_uploader: RTL and testbench

- Reader counterpart of the PRG downloader. On an HPS upload request it reads the BASIC end pointer from RAM and computes the program length.
- It then serves program bytes from the dpram to the MiSTer ioctl upload interface, so the running program can be saved as a PRG image.
- Sits beside the downloader and eraser on the shared memory-port mux. While `uploading` is high, the top level gives it the port and holds the CPU in reset.

---
 rtl/prg_uploader_if.sv | 34 +++
 rtl/prg_uploader.sv | 173 +++++++++++++++++
 tb/tb_prg_uploader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/prg_uploader_if.sv
// ============================================================================
// Module : prg_uploader_if
// Desc   : ioctl upload bus plus memory read port of the PRG uploader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface prg_uploader_if;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic [15:0] upload_size;
  logic        size_valid;
  logic        upload_err;
  logic        uploading;
  logic [24:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_dout;

  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, mem_dout,
    input  ioctl_din, upload_size, size_valid, upload_err, uploading,
           mem_addr, mem_rd
  );

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, mem_dout,
    output ioctl_din, upload_size, size_valid, upload_err, uploading,
           mem_addr, mem_rd
  );
endinterface

`default_nettype wire

// File: rtl/prg_uploader.sv
// ============================================================================
// Module : prg_uploader
// Desc   : Reads the BASIC END pointer, derives the PRG length and serves
//          program bytes from dpram to the ioctl upload interface.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module prg_uploader #(
  parameter logic [24:0] PRG_START_ADDR = 25'h10995,
  parameter logic [24:0] PTR_PROGND     = 25'h103E9,
  parameter logic [15:0] PTR_END_BASE   = 16'h8995,
  parameter logic [15:0] MAX_LEN        = 16'h766B
) (
  input  wire logic       F14Mx2,
  input  wire logic       reset_n,
  prg_uploader_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PTR_LO   = 3'd1,
    PTR_HI   = 3'd2,
    LATCH_HI = 3'd3,
    CALC     = 3'd4,
    SERVE    = 3'd5,
    FETCH    = 3'd6,
    WAIT_D   = 3'd7
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_upload_q;
  logic [7:0]  r_end_lo, w_end_lo_nxt;
  logic [7:0]  r_end_hi, w_end_hi_nxt;
  logic        r_oor, w_oor_nxt;
  logic [7:0]  r_din, w_din_nxt;
  logic [15:0] r_size, w_size_nxt;
  logic        r_size_valid, w_size_valid_nxt;
  logic        r_err, w_err_nxt;
  logic        r_uploading, w_uploading_nxt;
  logic [24:0] r_mem_addr, w_mem_addr_nxt;
  logic        r_mem_rd, w_mem_rd_nxt;

  logic [15:0] w_end;
  logic [15:0] w_len;
  logic        w_bad_ptr;
  logic        w_in_range;
  logic        w_start;

  assign w_end      = {r_end_hi, r_end_lo};
  assign w_len      = w_end - PTR_END_BASE;
  assign w_bad_ptr  = (w_end < PTR_END_BASE) || (w_len > MAX_LEN);
  // Full 25-bit compare so high offset bits can never alias into the image.
  assign w_in_range = bus.ioctl_addr < {9'd0, r_size};
  assign w_start    = (r_state == IDLE) && bus.ioctl_upload && !r_upload_q;

  always_ff @(posedge F14Mx2 or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_upload_q   <= 1'b0;
      r_end_lo     <= 8'd0;
      r_end_hi     <= 8'd0;
      r_oor        <= 1'b0;
      r_din        <= 8'd0;
      r_size       <= 16'd0;
      r_size_valid <= 1'b0;
      r_err        <= 1'b0;
      r_uploading  <= 1'b0;
      r_mem_addr   <= 25'd0;
      r_mem_rd     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_upload_q   <= bus.ioctl_upload;
      r_end_lo     <= w_end_lo_nxt;
      r_end_hi     <= w_end_hi_nxt;
      r_oor        <= w_oor_nxt;
      r_din        <= w_din_nxt;
      r_size       <= w_size_nxt;
      r_size_valid <= w_size_valid_nxt;
      r_err        <= w_err_nxt;
      r_uploading  <= w_uploading_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_rd     <= w_mem_rd_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_end_lo_nxt     = r_end_lo;
    w_end_hi_nxt     = r_end_hi;
    w_oor_nxt        = r_oor;
    w_din_nxt        = r_din;
    w_size_nxt       = r_size;
    w_size_valid_nxt = r_size_valid;
    w_err_nxt        = r_err;
    w_uploading_nxt  = r_uploading;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_rd_nxt     = r_mem_rd;

    if ((r_state != IDLE) && !bus.ioctl_upload) begin
      // Session dropped: release the port, keep size/err for the host to inspect.
      w_state_nxt      = IDLE;
      w_uploading_nxt  = 1'b0;
      w_mem_rd_nxt     = 1'b0;
      w_size_valid_nxt = 1'b0;
      w_oor_nxt        = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            w_state_nxt      = PTR_LO;
            w_mem_addr_nxt   = PTR_PROGND;
            w_mem_rd_nxt     = 1'b1;
            w_uploading_nxt  = 1'b1;
            w_size_valid_nxt = 1'b0;
            w_err_nxt        = 1'b0;
          end
        end
        PTR_LO: begin
          w_state_nxt    = PTR_HI;
          w_mem_addr_nxt = PTR_PROGND + 25'd1;
        end
        PTR_HI: begin
          w_end_lo_nxt = bus.mem_dout;
          w_mem_rd_nxt = 1'b0;
          w_state_nxt  = LATCH_HI;
        end
        LATCH_HI: begin
          w_end_hi_nxt = bus.mem_dout;
          w_state_nxt  = CALC;
        end
        CALC: begin
          w_size_nxt       = w_bad_ptr ? 16'd0 : w_len;
          w_err_nxt        = w_bad_ptr;
          w_size_valid_nxt = 1'b1;
          w_state_nxt      = SERVE;
        end
        SERVE: begin
          if (bus.ioctl_rd) begin
            w_state_nxt = FETCH;
            if (w_in_range) begin
              w_mem_addr_nxt = PRG_START_ADDR + {9'd0, bus.ioctl_addr[15:0]};
              w_mem_rd_nxt   = 1'b1;
            end else begin
              w_oor_nxt = 1'b1;
            end
          end
        end
        FETCH: begin
          w_mem_rd_nxt = 1'b0;
          w_state_nxt  = WAIT_D;
        end
        WAIT_D: begin
          w_din_nxt   = r_oor ? 8'h00 : bus.mem_dout;
          w_oor_nxt   = 1'b0;
          w_state_nxt = SERVE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign bus.ioctl_din   = r_din;
  assign bus.upload_size = r_size;
  assign bus.size_valid  = r_size_valid;
  assign bus.upload_err  = r_err;
  assign bus.uploading   = r_uploading;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_rd      = r_mem_rd;

endmodule

`default_nettype wire

// File: tb/tb_prg_uploader.sv
// ============================================================================
// Module : tb_prg_uploader
// Desc   : Self-checking bench for prg_uploader with a 1-latency memory model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prg_uploader;

  localparam logic [24:0] C_PRG_START = 25'h10995;
  localparam logic [24:0] C_PTR       = 25'h103E9;

  logic clk;
  logic reset_n;
  prg_uploader_if bus ();

  prg_uploader dut (
    .F14Mx2  (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:131071];
  logic [7:0] r_mem_q = 8'd0;
  int         rd_cycles = 0;

  always @(posedge clk) begin
    if (bus.mem_rd) begin
      r_mem_q <= mem[bus.mem_addr[16:0]];
      rd_cycles = rd_cycles + 1;
    end
  end
  assign bus.mem_dout = r_mem_q;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [15:0] end_ptr;
    logic [15:0] exp_size;
    logic        exp_err;
  } len_vec_t;

  typedef struct {
    logic [24:0] addr;
    logic        exp_rd;
  } rd_vec_t;

  len_vec_t lv [5];
  rd_vec_t  rv [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [24:0] a, input logic [15:0] sz);
    logic [24:0] p;
    p = C_PRG_START + {9'd0, a[15:0]};
    return (a < {9'd0, sz}) ? mem[p[16:0]] : 8'h00;
  endfunction

  task automatic start_session(input logic [15:0] ep, input logic [15:0] es, input logic ee);
    mem[17'h103E9] = ep[7:0];
    mem[17'h103EA] = ep[15:8];
    bus.ioctl_upload = 1'b0;
    tick();
    bus.ioctl_upload = 1'b1;
    tick();
    chk("start_uploading", {31'd0, bus.uploading}, 32'd1);
    chk("start_mem_rd", {31'd0, bus.mem_rd}, 32'd1);
    chk("start_mem_addr", {7'd0, bus.mem_addr}, {7'd0, C_PTR});
    chk("start_valid_clr", {31'd0, bus.size_valid}, 32'd0);
    tick();
    chk("ptr_hi_addr", {7'd0, bus.mem_addr}, {7'd0, C_PTR + 25'd1});
    tick();
    chk("ptr_rd_drop", {31'd0, bus.mem_rd}, 32'd0);
    tick();
    chk("calc_not_valid", {31'd0, bus.size_valid}, 32'd0);
    tick();
    chk("size_valid", {31'd0, bus.size_valid}, 32'd1);
    chk("upload_size", {16'd0, bus.upload_size}, {16'd0, es});
    chk("upload_err", {31'd0, bus.upload_err}, {31'd0, ee});
  endtask

  task automatic do_read(input logic [24:0] a, input logic exp_rd, input logic [15:0] sz);
    int rc;
    logic [7:0] e;
    exp_q.push_back(model_byte(a, sz));
    rc = rd_cycles;
    bus.ioctl_rd   = 1'b1;
    bus.ioctl_addr = a;
    tick();
    bus.ioctl_rd = 1'b0;
    chk("rd_strobe", {31'd0, bus.mem_rd}, {31'd0, exp_rd});
    if (exp_rd)
      chk("rd_addr", {7'd0, bus.mem_addr}, {7'd0, C_PRG_START + {9'd0, a[15:0]}});
    tick();
    tick();
    e = exp_q.pop_front();
    chk("rd_data", {24'd0, bus.ioctl_din}, {24'd0, e});
    chk("rd_pulses", rd_cycles - rc, exp_rd ? 32'd1 : 32'd0);
  endtask

  initial begin
    int rc;
    logic [7:0] e;

    // 0xFFFF minus the base is 0x766A, inside MAX_LEN, so it is a legal pointer.
    lv[0] = '{16'h8990, 16'h0000, 1'b1};
    lv[1] = '{16'h8995, 16'h0000, 1'b0};
    lv[2] = '{16'hFFFF, 16'h766A, 1'b0};
    lv[3] = '{16'h0000, 16'h0000, 1'b1};
    lv[4] = '{16'h9000, 16'h066B, 1'b0};

    rv[0] = '{25'h0000000, 1'b1};
    rv[1] = '{25'h0000005, 1'b1};
    rv[2] = '{25'h000000A, 1'b1};
    rv[3] = '{25'h000000B, 1'b0};
    rv[4] = '{25'h0010003, 1'b0};

    for (int i = 0; i < 131072; i++) mem[i] = 8'((i * 7) + 3);
    mem[17'h10995] = 8'h5A;

    reset_n          = 1'b0;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = 25'd0;
    #12;
    chk("rst_uploading", {31'd0, bus.uploading}, 32'd0);
    chk("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("rst_mem_addr", {7'd0, bus.mem_addr}, 32'd0);
    chk("rst_din_size", {8'd0, bus.ioctl_din, bus.upload_size}, 32'd0);
    chk("rst_flags", {30'd0, bus.size_valid, bus.upload_err}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Ordinary session and table-driven reads.
    start_session(16'h89A0, 16'h000B, 1'b0);
    for (int i = 0; i < 5; i++) do_read(rv[i].addr, rv[i].exp_rd, 16'h000B);

    // Second strobe lands in FETCH and must be ignored.
    exp_q.push_back(model_byte(25'd2, 16'h000B));
    rc = rd_cycles;
    bus.ioctl_rd = 1'b1;
    bus.ioctl_addr = 25'd2;
    tick();
    bus.ioctl_addr = 25'd7;
    tick();
    bus.ioctl_rd = 1'b0;
    tick();
    e = exp_q.pop_front();
    chk("busy_data", {24'd0, bus.ioctl_din}, {24'd0, e});
    tick();
    chk("busy_pulses", rd_cycles - rc, 32'd1);

    bus.ioctl_upload = 1'b0;
    tick();
    chk("end_uploading", {31'd0, bus.uploading}, 32'd0);
    chk("end_valid", {31'd0, bus.size_valid}, 32'd0);
    chk("end_size_kept", {16'd0, bus.upload_size}, 32'h000B);

    for (int i = 0; i < 5; i++) begin
      start_session(lv[i].end_ptr, lv[i].exp_size, lv[i].exp_err);
      bus.ioctl_upload = 1'b0;
      tick();
      chk("len_err_kept", {31'd0, bus.upload_err}, {31'd0, lv[i].exp_err});
    end

    // Abort during the pointer fetch, then restart from scratch.
    bus.ioctl_upload = 1'b1;
    tick();
    tick();
    bus.ioctl_upload = 1'b0;
    tick();
    chk("abort_uploading", {31'd0, bus.uploading}, 32'd0);
    chk("abort_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("abort_valid", {31'd0, bus.size_valid}, 32'd0);
    rc = rd_cycles;
    repeat (5) tick();
    chk("abort_quiet", rd_cycles - rc, 32'd0);
    start_session(16'h89A0, 16'h000B, 1'b0);
    do_read(25'd0, 1'b1, 16'h000B);

    // Asynchronous reset while the read sits in WAIT_D.
    bus.ioctl_rd = 1'b1;
    bus.ioctl_addr = 25'd3;
    tick();
    bus.ioctl_rd = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_outputs", {bus.ioctl_din, bus.upload_size, 5'd0, bus.size_valid,
                         bus.upload_err, bus.uploading}, 32'd0);
    chk("arst_mem", {6'd0, bus.mem_rd, bus.mem_addr}, 32'd0);
    bus.ioctl_upload = 1'b0;
    #2 reset_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", {30'd0, bus.uploading, bus.mem_rd}, 32'd0);
    start_session(16'h89A0, 16'h000B, 1'b0);
    do_read(25'd10, 1'b1, 16'h000B);
    bus.ioctl_upload = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
